// File: rtl/carloni_fifo_ctrl.sv
// Stop/void shell controller around a non-showahead FIFO.
// Read data lands in a credit-managed skid buffer.
module carloni_fifo_ctrl #(
  parameter int WIDTH = 16,
  parameter int RD_LAT = 2,
  parameter int SKID = RD_LAT + 1,
  localparam int OCC_W = $clog2(SKID + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_void,
  output logic             o_stop,
  output logic             f_enq,
  output logic [WIDTH-1:0] f_data,
  output logic             f_deq,
  input  logic [WIDTH-1:0] f_q,
  input  logic             f_almost_full,
  input  logic             f_full,
  input  logic             f_empty,
  output logic [WIDTH-1:0] o_data,
  output logic             o_void,
  input  logic             i_stop,
  output logic [OCC_W-1:0] o_occ
);

  localparam int PW = $clog2(SKID);
  localparam int CW = $clog2(SKID + RD_LAT + 2);

  logic [RD_LAT-1:0] inflight;
  logic [RD_LAT-1:0] inflight_nxt;
  logic [WIDTH-1:0]  mem [SKID];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [OCC_W-1:0]  count;
  logic              push;
  logic              pop;
  logic [CW-1:0]     inf_cnt;
  logic [CW-1:0]     used;

  function automatic logic [PW-1:0] nxt_ptr(
    input logic [PW-1:0] p
  );
    return (p == PW'(SKID - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_stop = !reset | f_almost_full | f_full;
  assign f_enq  = !i_void & !o_stop;
  assign f_data = i_data;
  assign o_void = (count == '0);
  assign o_occ  = count;
  assign o_data = mem[rd_ptr];
  assign pop    = !o_void & !i_stop;
  assign push   = inflight[0];

  always_comb begin
    inf_cnt = '0;
    for (int i = 0; i < RD_LAT; i++)
      inf_cnt = inf_cnt + CW'(inflight[i]);
  end

  // Words buffered plus words in flight must leave room;
  // a same-cycle pop returns one credit.
  assign used  = CW'(count) + inf_cnt;
  assign f_deq = reset & !f_empty
               & (used < CW'(SKID) + CW'(pop));

  always_comb begin
    inflight_nxt = inflight >> 1;
    inflight_nxt[RD_LAT-1] = f_deq;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (push) wr_ptr <= nxt_ptr(wr_ptr);
      if (pop)  rd_ptr <= nxt_ptr(rd_ptr);
      count <= count + OCC_W'(push) - OCC_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= f_q;
  end

  a_no_skid_overflow: assert property (
    @(posedge clk) disable iff (!reset)
    !(push && (count == OCC_W'(SKID)) && !pop)
  );

endmodule

// File: tb/tb_carloni_fifo_ctrl.sv
// Bench for carloni_fifo_ctrl: FIFO model plus
// input-to-output scoreboard with a decoupled monitor.
module tb_carloni_fifo_ctrl;

  localparam int W = 16;
  localparam int RL = 2;
  localparam int SK = RL + 1;
  localparam int OW = $clog2(SK + 1);
  localparam int DEPTH = 8;

  logic          clk = 0;
  logic          reset;
  logic [W-1:0]  i_data;
  logic          i_void;
  logic          o_stop;
  logic          f_enq;
  logic [W-1:0]  f_data;
  logic          f_deq;
  logic [W-1:0]  f_q;
  logic          f_almost_full;
  logic          f_full;
  logic          f_empty;
  logic [W-1:0]  o_data;
  logic          o_void;
  logic          i_stop;
  logic [OW-1:0] o_occ;

  carloni_fifo_ctrl #(.WIDTH(W), .RD_LAT(RL), .SKID(SK)) dut (
    .clk(clk), .reset(reset),
    .i_data(i_data), .i_void(i_void), .o_stop(o_stop),
    .f_enq(f_enq), .f_data(f_data), .f_deq(f_deq),
    .f_q(f_q), .f_almost_full(f_almost_full),
    .f_full(f_full), .f_empty(f_empty),
    .o_data(o_data), .o_void(o_void), .i_stop(i_stop),
    .o_occ(o_occ)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // FIFO model: registered read, RL-cycle data pipe
  logic [W-1:0] fm [DEPTH];
  logic [3:0]   fcnt;
  logic [2:0]   fwp, frp;
  logic [W-1:0] rpipe [RL];

  assign f_empty       = (fcnt == 0);
  assign f_full        = (fcnt == DEPTH);
  assign f_almost_full = (fcnt >= DEPTH - 1);
  assign f_q           = rpipe[RL-1];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fcnt <= 0;
      fwp  <= 0;
      frp  <= 0;
      for (int i = 0; i < RL; i++) rpipe[i] <= 16'hDEAD;
    end else begin
      if (f_enq) begin
        chk("fifo_no_overflow", 32'(fcnt == DEPTH), 0);
        fm[fwp] <= f_data;
        fwp <= fwp + 1;
      end
      if (f_deq) begin
        chk("fifo_no_underflow", 32'(fcnt == 0), 0);
        frp <= frp + 1;
      end
      rpipe[0] <= f_deq ? fm[frp] : 16'hDEAD;
      for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
      fcnt <= fcnt + 4'(f_enq) - 4'(f_deq);
    end
  end

  // Scoreboard and monitor
  logic [W-1:0] exp_q [$];
  logic [W-1:0] ew;
  int first_in = -1, first_out = -1, last_out = -1;
  int n_out = 0, peak = 0;
  bit chk_credit = 0, chk_af = 0, saw_stop = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (!i_void && !o_stop) begin
        exp_q.push_back(i_data);
        if (first_in < 0) first_in = cyc;
      end
      if (!o_void && !i_stop) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        n_out++;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_word", 32'(o_data), 32'hFFFF_FFFF);
        end else begin
          ew = exp_q.pop_front();
          chk("sb_data", 32'(o_data), 32'(ew));
        end
      end
      if (32'(o_occ) > peak) peak = 32'(o_occ);
      if (chk_credit && i_stop && o_occ == OW'(SK))
        chk("credit_zero_no_deq", 32'(f_deq), 0);
      if (chk_af) begin
        chk("stop_eq_af", 32'(o_stop),
            32'(f_almost_full | f_full));
        if (o_stop) begin
          saw_stop = 1;
          chk("no_enq_when_stop", 32'(f_enq), 0);
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] w);
    int n;
    n = 0;
    i_data = w;
    i_void = 0;
    forever begin
      @(negedge clk);
      if (!o_stop) break;
      n++;
      if (n > 2000) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    i_void = 1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("drain_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic mark();
    first_in = -1;
    first_out = -1;
    last_out = -1;
    n_out = 0;
    peak = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  bit done5;
  int n;

  initial begin
    void'($urandom(32'h5EED));
    reset = 0;
    i_void = 0;
    i_data = 16'h1234;
    i_stop = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_stop", 32'(o_stop), 1);
    chk("rst_f_enq", 32'(f_enq), 0);
    chk("rst_f_deq", 32'(f_deq), 0);
    chk("rst_o_void", 32'(o_void), 1);
    chk("rst_o_occ", 32'(o_occ), 0);
    i_void = 1;
    reset = 1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_o_void", 32'(o_void), 1);
      chk("idle_o_stop", 32'(o_stop), 0);
      chk("idle_f_deq", 32'(f_deq), 0);
      chk("idle_o_occ", 32'(o_occ), 0);
    end
    @(posedge clk);
    #1;

    // Streaming: fill latency 4, then one word per cycle
    mark();
    for (int k = 1; k <= 16; k++) send(W'(k));
    drain();
    chk("fill_latency", 32'(first_out - first_in), 4);
    chk("stream_span", 32'(last_out - first_out), 15);
    chk("stream_count", 32'(n_out), 16);

    // Downstream stop during a stream
    mark();
    chk_credit = 1;
    fork
      for (int k = 0; k < 16; k++) send(16'h0100 + W'(k));
      begin
        repeat (6) @(posedge clk);
        #1;
        i_stop = 1;
        repeat (10) @(posedge clk);
        #1;
        i_stop = 0;
        @(negedge clk);
        chk("resume_deq", 32'(f_deq), 1);
      end
    join
    drain();
    chk_credit = 0;
    chk("stop_peak_occ", 32'(peak), SK);
    chk("stop_count", 32'(n_out), 16);

    // Permanent stop: upstream backpressure from almost-full
    chk_af = 1;
    i_stop = 1;
    fork
      for (int k = 0; k < 14; k++) send(16'h0200 + W'(k));
      begin
        repeat (40) @(posedge clk);
        #1;
        chk("af_saw_stop", 32'(saw_stop), 1);
        chk("af_accepted", 32'(exp_q.size()), 10);
        chk("af_occ_full", 32'(o_occ), SK);
        i_stop = 0;
      end
    join
    drain();
    chk_af = 0;

    // Alternating voids, stop toggling every 3 cycles
    mark();
    done5 = 0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          i_void = 1;
          @(posedge clk);
          #1;
          send(W'($urandom));
        end
        done5 = 1;
      end
      begin
        while (!done5) begin
          repeat (3) @(posedge clk);
          #1;
          i_stop = !i_stop;
        end
      end
    join
    i_stop = 0;
    drain();
    chk("rand_count", 32'(n_out), 40);

    // Mid-operation reset with reads in flight
    i_stop = 1;
    for (int k = 0; k < 4; k++) send(16'h0300 + W'(k));
    n = 0;
    forever begin
      @(negedge clk);
      if (o_occ == 2) break;
      n++;
      if (n > 50) begin
        chk("wait_occ2_timeout", 1, 0);
        break;
      end
    end
    #1;
    reset = 0;
    #1;
    chk("midrst_o_void", 32'(o_void), 1);
    chk("midrst_o_occ", 32'(o_occ), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1;
    i_stop = 0;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_no_stale", 32'(o_void), 1);
    end
    chk("post_rst_sb_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
